fft_bitrev: RTL and testbench

//  Input reorder buffer for the streaming radix-2 DIT FFT; sits directly upstream of fft_stage1.

---
 rtl/fft_bitrev.sv | 121 ++++++++++++
 tb/tb_fft_bitrev.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bitrev.sv
// -----------------------------------------------------------------------------
// fft_bitrev
//   Input reorder buffer for the streaming radix-2 DIT FFT. Samples arrive in
//   natural order and each N-sample frame is emitted in bit-reversed order as
//   one contiguous burst of N cycles, since the downstream stage has no
//   backpressure. Two banks alternate between the write and read roles, which
//   sustains one sample per cycle with back-to-back frames.
//
// Parameters
//   N           FFT length in samples per frame (power of two, >= 2)
//   DATA_WIDTH  width of each of re and im
//
// Ports
//   clk        clock; all state updates on posedge
//   rst_n      asynchronous active-low reset
//   din        input sample {re, im}, natural order
//   in_valid   din is valid this cycle
//   in_ready   block accepts din this cycle (current write bank not full)
//   dout       output sample {re, im}, bit-reversed order (registered)
//   out_valid  dout is valid
//   out_last   marks the final sample of a frame, together with out_valid
// -----------------------------------------------------------------------------
module fft_bitrev #(
    parameter int N          = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic signed [0:1][DATA_WIDTH-1:0]  din,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic signed [0:1][DATA_WIDTH-1:0]  dout,
    output logic                               out_valid,
    output logic                               out_last
);

    localparam int LOG2_N = $clog2(N);
    localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(N - 1);

    typedef logic [0:1][DATA_WIDTH-1:0] sample_t;

    sample_t           mem [2][N];
    logic [1:0]        full;
    logic              wr_bank;
    logic              rd_bank;
    logic [LOG2_N-1:0] wr_idx;
    logic [LOG2_N-1:0] rd_idx;
    logic              wr_en;
    logic              rd_en;

    // Mirror the index bits: bit i of the result is bit LOG2_N-1-i of idx.
    function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] idx);
        logic [LOG2_N-1:0] r;
        for (int i = 0; i < LOG2_N; i++) begin
            r[i] = idx[LOG2_N-1-i];
        end
        return r;
    endfunction

    // A bank can take new samples only once its previous frame has been read out.
    assign in_ready = ~full[wr_bank];
    assign wr_en    = in_valid & in_ready;
    // A bank that is full is by construction not the one being written, so
    // the reader never sees a half-written frame.
    assign rd_en    = full[rd_bank];

    // NOTE: storage arrays carry no reset; their contents are only ever read
    // after being written, and leaving them unreset lets them map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_idx] <= din;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full      <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_idx    <= '0;
            rd_idx    <= '0;
            dout      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            // Write side: fill the current bank, hand it to the reader when complete.
            if (wr_en) begin
                if (wr_idx == LAST_IDX) begin
                    wr_idx        <= '0;
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end

            // Read side: drain a full bank in bit-reversed order, one per cycle.
            // The set above and the clear below always address different banks.
            if (rd_en) begin
                dout      <= mem[rd_bank][bitrev(rd_idx)];
                out_valid <= 1'b1;
                if (rd_idx == LAST_IDX) begin
                    out_last      <= 1'b1;
                    rd_idx        <= '0;
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                end else begin
                    out_last <= 1'b0;
                    rd_idx   <= rd_idx + 1'b1;
                end
            end else begin
                // dout deliberately holds its last value while idle.
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_bitrev.sv
// -----------------------------------------------------------------------------
// tb_fft_bitrev
//   Self-checking bench for fft_bitrev. Frames are described by a table of
//   {input sample, expected output sample, expected last} rows; when a frame's
//   final sample is accepted, its expected outputs are pushed to a scoreboard
//   queue that the output monitor pops and compares. A second instance with
//   N=8, DATA_WIDTH=16 is exercised with a hand-written sequence.
// -----------------------------------------------------------------------------
module tb_fft_bitrev;

    localparam int N      = 32;
    localparam int DW     = 32;
    localparam int LOG2_N = 5;
    localparam int N8     = 8;
    localparam int DW8    = 16;

    typedef logic signed [0:1][DW-1:0]  sample_t;
    typedef logic signed [0:1][DW8-1:0] sample8_t;

    typedef struct {
        sample_t din;
        sample_t exp_dout;
        logic    exp_last;
    } row_t;

    typedef struct {
        sample_t s;
        logic    last;
    } exp_t;

    logic     clk = 1'b0;
    logic     rst_n = 1'b0;
    sample_t  din = '0;
    logic     in_valid = 1'b0;
    logic     in_ready;
    sample_t  dout;
    logic     out_valid;
    logic     out_last;

    sample8_t din8 = '0;
    logic     in_valid8 = 1'b0;
    logic     in_ready8;
    sample8_t dout8;
    logic     out_valid8;
    logic     out_last8;

    fft_bitrev #(.N(N), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dout      (dout),
        .out_valid (out_valid),
        .out_last  (out_last)
    );

    fft_bitrev #(.N(N8), .DATA_WIDTH(DW8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din8),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .dout      (dout8),
        .out_valid (out_valid8),
        .out_last  (out_last8)
    );

    always #5 clk = ~clk;

    int      errors = 0;
    int      checks = 0;
    exp_t    sb[$];
    row_t    tbl[N];
    int      neg_cnt = 0;
    int      first_out_neg = -1;
    logic    prev_valid = 1'b0;
    logic    prev_last = 1'b0;
    sample_t cap[N];
    int      cap_pos = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int bitrev_tb(input int k, input int bits);
        int r = 0;
        for (int i = 0; i < bits; i++) begin
            if (((k >> i) & 1) == 1) r = r | (1 << (bits - 1 - i));
        end
        return r;
    endfunction

    // Fill the expected columns of the table from its input column.
    task automatic finish_table();
        for (int j = 0; j < N; j++) begin
            tbl[j].exp_dout = tbl[bitrev_tb(j, LOG2_N)].din;
            tbl[j].exp_last = (j == N - 1);
        end
    endtask

    task automatic fill_ramp(input int base);
        for (int k = 0; k < N; k++) begin
            tbl[k].din[0] = DW'(base + k);
            tbl[k].din[1] = DW'(-k);
        end
        finish_table();
    endtask

    // Drive the first 'count' rows of tbl; in_valid is low with probability
    // gap_pct percent per cycle. A complete frame pushes its expected outputs
    // when its final sample is driven. in_valid is left as-is on return so
    // frames can follow back to back; call idle() afterwards.
    task automatic send_frame(input int count, input int gap_pct,
                              output int stalls, output int last_neg);
        int k = 0;
        exp_t e;
        stalls   = 0;
        last_neg = -1;
        while (k < count) begin
            @(negedge clk); #1;
            in_valid = ($urandom_range(99) >= gap_pct);
            din      = tbl[k].din;
            if (in_valid) begin
                if (in_ready) begin
                    if (k == N - 1) begin
                        for (int j = 0; j < N; j++) begin
                            e.s    = tbl[j].exp_dout;
                            e.last = tbl[j].exp_last;
                            sb.push_back(e);
                        end
                        last_neg = neg_cnt;
                    end
                    k++;
                end else begin
                    stalls++;
                    if (stalls > 500) begin
                        $display("FAIL in_ready_stuck: got 0 expected 1");
                        $fatal(1, "in_ready stuck low");
                    end
                end
            end
        end
    endtask

    task automatic idle();
        @(negedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((sb.size() != 0 || out_valid) && t < 500) begin
            @(negedge clk); #1;
            t++;
        end
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    // Output monitor: scoreboard compare, burst contiguity, capture.
    always @(negedge clk) begin
        exp_t e;
        neg_cnt++;
        if (rst_n) begin
            if (prev_valid && !prev_last) check("burst_contiguous", 64'(out_valid), 64'd1);
            if (out_valid) begin
                if (first_out_neg < 0) first_out_neg = neg_cnt;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL residual_output: got dout=%0h with empty scoreboard", dout);
                end else begin
                    e = sb.pop_front();
                    check("dout", dout, e.s);
                    check("out_last", 64'(out_last), 64'(e.last));
                end
                cap[cap_pos] = dout;
                cap_pos      = (cap_pos + 1) % N;
            end
            prev_valid = out_valid;
            prev_last  = out_last;
        end else begin
            prev_valid = 1'b0;
            prev_last  = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls;
        int last_neg;
        int total_stalls;
        int t;
        logic signed [DW-1:0] ar, br;
        logic [DW8-1:0] e16;
        int exp_re8[N8];
        int in_im8[N8];

        exp_re8 = '{0, 4, 2, 6, 1, 5, 3, 7};
        for (int k = 0; k < N8; k++) in_im8[k] = (k % 2 == 1) ? -32768 : -k;

        // Reset state, observed while reset is held.
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_last",  64'(out_last),  64'd0);
        check("rst_dout",      dout,           64'd0);
        check("rst_out_valid8", 64'(out_valid8), 64'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Case 1: ramp frame, continuous in_valid.
        fill_ramp(0);
        first_out_neg = -1;
        cap_pos = 0;
        send_frame(N, 0, stalls, last_neg);
        idle();
        wait_drain();
        check("latency_case1", 64'(first_out_neg), 64'(last_neg + 2));
        check("case1_re0",  64'(cap[0][0]),  64'd0);
        check("case1_re1",  64'(cap[1][0]),  64'd16);
        check("case1_re2",  64'(cap[2][0]),  64'd8);
        check("case1_re3",  64'(cap[3][0]),  64'd24);
        check("case1_re31", 64'(cap[31][0]), 64'd31);

        // Case 2: three back-to-back frames; in_ready must never drop.
        total_stalls = 0;
        for (int f = 0; f < 3; f++) begin
            fill_ramp(100 * f);
            send_frame(N, 0, stalls, last_neg);
            total_stalls += stalls;
        end
        idle();
        wait_drain();
        check("b2b_in_ready_stalls", 64'(total_stalls), 64'd0);

        // Case 3: random in_valid gaps.
        fill_ramp(0);
        first_out_neg = -1;
        send_frame(N, 50, stalls, last_neg);
        idle();
        wait_drain();
        check("latency_gaps", 64'(first_out_neg), 64'(last_neg + 2));

        // Case 4a: reset after 17 inputs.
        fill_ramp(500);
        send_frame(17, 0, stalls, last_neg);
        idle();
        #2 rst_n = 1'b0;
        #1;
        check("rst_partial_out_valid", 64'(out_valid), 64'd0);
        check("rst_partial_in_ready",  64'(in_ready),  64'd1);
        sb.delete();
        @(negedge clk); #1 rst_n = 1'b1;
        fill_ramp(700);
        send_frame(N, 0, stalls, last_neg);
        idle();
        wait_drain();

        // Case 4b: reset in the middle of a frame's output burst.
        fill_ramp(900);
        send_frame(N, 0, stalls, last_neg);
        idle();
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk); #1;
            t++;
        end
        check("burst_started", 64'(out_valid), 64'd1);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_out_last",  64'(out_last),  64'd0);
        check("rst_mid_dout",      dout,           64'd0);
        sb.delete();
        @(negedge clk); #1 rst_n = 1'b1;
        fill_ramp(1100);
        send_frame(N, 0, stalls, last_neg);
        idle();
        wait_drain();

        // Case 6: impulse frame, then a unit-twiddle butterfly over the
        // reordered stream. The impulse stays at position 0 after reordering,
        // so only pair 0 is non-zero: sum = diff = 1000.
        for (int k = 0; k < N; k++) tbl[k].din = '0;
        tbl[0].din[0] = DW'(1000);
        finish_table();
        cap_pos = 0;
        send_frame(N, 0, stalls, last_neg);
        idle();
        wait_drain();
        for (int p = 0; p < N / 2; p++) begin
            ar = cap[2*p][0];
            br = cap[2*p+1][0];
            check("bfly_sum",  64'(int'(ar) + int'(br)), 64'((p == 0) ? 1000 : 0));
            check("bfly_diff", 64'(int'(ar) - int'(br)), 64'((p == 0) ? 1000 : 0));
        end

        // Case 5: N=8, DATA_WIDTH=16 instance with negative values.
        for (int k = 0; k < N8; k++) begin
            @(negedge clk); #1;
            in_valid8 = 1'b1;
            din8[0]   = DW8'(k);
            din8[1]   = DW8'(in_im8[k]);
        end
        @(negedge clk); #1;
        in_valid8 = 1'b0;
        t = 0;
        while (!out_valid8 && t < 20) begin
            @(negedge clk); #1;
            t++;
        end
        for (int j = 0; j < N8; j++) begin
            check("n8_valid", 64'(out_valid8), 64'd1);
            e16 = DW8'(exp_re8[j]);
            check("n8_re", 64'(dout8[0]), 64'(e16));
            e16 = DW8'(in_im8[exp_re8[j]]);
            check("n8_im", 64'(dout8[1]), 64'(e16));
            check("n8_last", 64'(out_last8), 64'(j == N8 - 1));
            @(negedge clk); #1;
        end
        check("n8_idle_after", 64'(out_valid8), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
